// File: rtl/memory_pkg.sv
// Shared widths, defaults and types for the memory block.
// The optional range check is enabled by defining MEMORY_BOUNDS_CHECK_EN.
package memory_pkg;

  localparam int WORD_W       = 32;
  localparam int MASK_W       = WORD_W / 8;
  localparam int DEF_SIZE     = 1024;
  localparam int DEF_LATENCY  = 4;
  localparam int DEF_INTERVAL = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MASK_W-1:0] mask_t;

  // One slot of the read-response delay line.
  typedef struct packed {
    logic  valid;
    word_t data;
  } resp_t;

endpackage

// File: rtl/memory_resp_pipe.sv
// Fixed-latency read-response delay line: LATENCY stages of {valid, data}.
// Data is zeroed on entry when not valid, so the output is 0 between responses.
module memory_resp_pipe
  import memory_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_valid,
  input  word_t i_data,
  output logic  o_valid,
  output word_t o_data
);

  resp_t [LATENCY-1:0] stage_q;
  resp_t [LATENCY-1:0] stage_d;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_d[gi].valid = i_valid;
      assign stage_d[gi].data  = i_valid ? i_data : '0;
    end else begin : g_body
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  // Reset flushes every slot so no response can surface after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_valid = stage_q[LATENCY-1].valid;
  assign o_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/memory.sv
// Word-addressed memory with byte lanes, fixed read latency and request interval.
// Define MEMORY_BOUNDS_CHECK_EN to drop/zero accesses above the array instead of wrapping.
module memory
  import memory_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int LATENCY  = DEF_LATENCY,
  parameter int INTERVAL = DEF_INTERVAL
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_ready,
  input  logic [31:0]       i_addr,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [WORD_W-1:0] i_wdata,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int AW    = $clog2(SIZE);
  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INTERVAL - 1);

  word_t mem [0:SIZE-1];

  logic [AW-1:0]    idx;
  logic             in_range;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  word_t            lane_bits;
  word_t            rd_data;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pipe_valid;
  word_t            pipe_data;
  logic             unused_addr;

  assign idx         = i_addr[AW+1:2];
  assign unused_addr = ^{i_addr[1:0], i_addr[31:AW+2]};

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign in_range = (i_addr[31:AW+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  // A read+write request is a write; it still consumes an interval slot.
  assign accept = o_ready & (i_ren | i_wen);
  assign wr_en  = accept & i_wen & in_range;
  assign rd_en  = accept & i_ren & ~i_wen;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_ready = i_rst_n & (cnt_q == '0);

  for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane
    assign lane_bits[8*gi +: 8] = {8{i_mask[gi]}};
  end

  // Contents are deliberately not reset so preloaded images survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (i_mask[b]) begin
          mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = in_range ? (mem[idx] & lane_bits) : '0;

  memory_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (rd_en),
    .i_data  (rd_data),
    .o_valid (pipe_valid),
    .o_data  (pipe_data)
  );

  assign o_valid = pipe_valid;
  assign o_rdata = pipe_valid ? pipe_data : '0;

endmodule

// File: tb/tb_memory.sv
// Bench for memory: per-cycle reference model (array + timed response queue),
// a table of byte-lane vectors, hand-written corner sequences and random traffic.
module tb_memory;

  localparam int SIZE = 1024;
  localparam int LAT  = 4;
  localparam int INTV = 2;
  localparam int AW   = 10;
`ifdef MEMORY_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        o_ready;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        o_valid;
  logic [31:0] o_rdata;

  memory #(.SIZE(SIZE), .LATENCY(LAT), .INTERVAL(INTV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_ready (o_ready),
    .i_addr  (addr),
    .i_ren   (ren),
    .i_wen   (wen),
    .i_mask  (mask),
    .i_wdata (wdata),
    .o_valid (o_valid),
    .o_rdata (o_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [3:0]  rmask;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] model_mem [SIZE];
  exp_t        exp_q [$];
  int          resp_cyc [$];
  logic [31:0] resp_dat [$];
  int          cyc      = 0;
  int          last_acc = -1000;
  bit          m_acc    = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d actual=missing required=present", name, cyc);
  endtask

  function automatic logic m_ready();
    return rst_n && ((cyc - last_acc) >= INTV);
  endfunction

  function automatic bit m_inr(input logic [31:0] a);
    return !BOUNDS || ((a >> (AW + 2)) == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] w;
    logic [31:0] r;
    w = model_mem[int'((a >> 2) % SIZE)];
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    end
    return m_inr(a) ? r : 32'h0;
  endfunction

  // One clock: check outputs mid-cycle, then apply the model at the edge.
  task automatic step();
    logic        ev;
    logic [31:0] ed;
    int          wi;
    @(negedge clk);
    ev = 1'b0;
    ed = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev = 1'b1;
      ed = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("ready", {31'h0, o_ready}, {31'h0, m_ready()});
    chk("valid", {31'h0, o_valid}, {31'h0, ev});
    chk("rdata", o_rdata, ed);
    if (o_valid) begin
      resp_cyc.push_back(cyc);
      resp_dat.push_back(o_rdata);
    end
    @(posedge clk);
    m_acc = 1'b0;
    if (m_ready() && (ren || wen)) begin
      m_acc    = 1'b1;
      last_acc = cyc;
      if (wen) begin
        if (m_inr(addr)) begin
          wi = int'((addr >> 2) % SIZE);
          for (int b = 0; b < 4; b++) begin
            if (mask[b]) model_mem[wi][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        $display("cyc=%0d WR addr=%h mask=%b wdata=%h", cyc, addr, mask, wdata);
      end else begin
        exp_q.push_back('{due: cyc + LAT, data: m_read(addr, mask)});
        $display("cyc=%0d RD addr=%h mask=%b", cyc, addr, mask);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] m, input logic [31:0] d, output int acc);
    addr  = a;
    ren   = r;
    wen   = w;
    mask  = m;
    wdata = d;
    acc   = -1;
    for (int k = 0; k < INTV + 2; k++) begin
      step();
      if (m_acc) begin
        acc = cyc - 1;
        break;
      end
    end
    ren = 1'b0;
    wen = 1'b0;
    if (acc < 0) fail_now("issue_timeout");
  endtask

  task automatic expect_resp(input int acc, input logic [31:0] exp, input string name);
    int hit;
    hit = -1;
    for (int k = 0; k < resp_cyc.size(); k++) begin
      if (resp_cyc[k] == acc + LAT) hit = k;
    end
    if (hit < 0) fail_now(name);
    else chk(name, resp_dat[hit], exp);
  endtask

  task automatic clear_log();
    resp_cyc.delete();
    resp_dat.delete();
  endtask

  task automatic poke(input int i, input logic [31:0] v);
    dut.mem[i]   = v;
    model_mem[i] = v;
  endtask

  vec_t vecs [6];

  initial begin
    int          a0, a1, a2;
    int          c0;
    logic [31:0] ra;

    rst_n = 1'b0;
    addr  = 32'h0;
    ren   = 1'b0;
    wen   = 1'b0;
    mask  = 4'h0;
    wdata = 32'h0;
    for (int i = 0; i < SIZE; i++) poke(i, i * 32'h9E3779B9);
    poke(0, 32'h0000_0013);

    vecs[0] = '{32'h0000_0008, 32'h1122_3344, 4'b0010, 32'hAABB_CCDD, 4'b1111, 32'h1122_CC44};
    vecs[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b0000, 32'h0000_0000, 4'b1100, 32'hDEAD_0000};
    vecs[2] = '{32'h0000_0014, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 4'b0001, 32'h0000_000D};
    vecs[3] = '{32'h0000_001B, 32'h1234_5678, 4'b1001, 32'hAABB_CCDD, 4'b1111, 32'hAA34_56DD};
    vecs[4] = '{32'h0000_0FFC, 32'h0000_0000, 4'b0100, 32'h00EE_0000, 4'b0110, 32'h00EE_0000};
    vecs[5] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0102_0304, 4'b0000, 32'h0000_0000};

    wait_cycles(3);
    rst_n    = 1'b1;
    last_acc = -1000;

    // Preloaded word comes back exactly LATENCY cycles after acceptance.
    clear_log();
    issue(32'h0, 1'b1, 1'b0, 4'hF, 32'h0, a0);
    wait_cycles(LAT + 2);
    expect_resp(a0, 32'h0000_0013, "preload");
    chk("preload_once", resp_cyc.size(), 1);

    foreach (vecs[i]) begin
      clear_log();
      issue(vecs[i].addr, 1'b0, 1'b1, 4'hF, vecs[i].base, a0);
      issue(vecs[i].addr, 1'b0, 1'b1, vecs[i].wmask, vecs[i].wdata, a1);
      issue(vecs[i].addr, 1'b1, 1'b0, vecs[i].rmask, 32'h0, a2);
      wait_cycles(LAT);
      expect_resp(a2, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Held read request: accepted, ignored, accepted.
    clear_log();
    c0    = cyc;
    addr  = 32'h4;
    mask  = 4'hF;
    ren   = 1'b1;
    wait_cycles(3);
    ren = 1'b0;
    wait_cycles(6);
    chk("intv_count", resp_cyc.size(), 2);
    if (resp_cyc.size() == 2) begin
      chk("intv_first", resp_cyc[0], c0 + 4);
      chk("intv_second", resp_cyc[1], c0 + 6);
    end

    // Read+write together behaves as a write only.
    clear_log();
    issue(32'h30, 1'b1, 1'b1, 4'hF, 32'h0000_0077, a0);
    wait_cycles(LAT + 2);
    chk("rw_noresp", resp_cyc.size(), 0);
    issue(32'h30, 1'b1, 1'b0, 4'hF, 32'h0, a1);
    wait_cycles(LAT);
    expect_resp(a1, 32'h0000_0077, "rw_written");

    // Read before a same-address write sees old data; read after sees new.
    clear_log();
    issue(32'h40, 1'b0, 1'b1, 4'hF, 32'h1111_1111, a0);
    issue(32'h40, 1'b1, 1'b0, 4'hF, 32'h0, a1);
    issue(32'h40, 1'b0, 1'b1, 4'hF, 32'h2222_2222, a2);
    wait_cycles(LAT);
    expect_resp(a1, 32'h1111_1111, "raw_old");
    issue(32'h40, 1'b1, 1'b0, 4'hF, 32'h0, a0);
    wait_cycles(LAT);
    expect_resp(a0, 32'h2222_2222, "raw_new");

    // Reset two cycles after a read acceptance kills the response.
    clear_log();
    issue(32'h8, 1'b1, 1'b0, 4'hF, 32'h0, a0);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    wait_cycles(3);
    rst_n    = 1'b1;
    last_acc = -1000;
    wait_cycles(LAT + 1);
    chk("rst_noresp", resp_cyc.size(), 0);
    issue(32'h8, 1'b1, 1'b0, 4'hF, 32'h0, a1);
    wait_cycles(LAT);
    expect_resp(a1, 32'h1122_CC44, "rst_mem_kept");

    // Address above the array: wraps onto word 0, or is dropped when bounds-checked.
    poke(0, 32'h0000_0013);
    clear_log();
    issue(32'h1000, 1'b0, 1'b1, 4'hF, 32'h5A5A_5A5A, a0);
    issue(32'h0, 1'b1, 1'b0, 4'hF, 32'h0, a1);
    issue(32'h1000, 1'b1, 1'b0, 4'hF, 32'h0, a2);
    wait_cycles(LAT);
    expect_resp(a1, BOUNDS ? 32'h0000_0013 : 32'h5A5A_5A5A, "wrap_word0");
    expect_resp(a2, BOUNDS ? 32'h0000_0000 : 32'h5A5A_5A5A, "wrap_high");

    // Random traffic over a few words, with occasional high address bits.
    for (int n = 0; n < 300; n++) begin
      ra    = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) << 12 : 32'h0;
      addr  = ra | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      ren   = $urandom_range(0, 1) == 1;
      wen   = $urandom_range(0, 3) == 0;
      mask  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      step();
    end
    ren = 1'b0;
    wen = 1'b0;
    wait_cycles(LAT + 2);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
